// File: rtl/ctrl_fsm_rv32_if.sv
// Handshake bundle between the RV32 control FSM and its fetch/memory/muldiv environment.
interface ctrl_fsm_rv32_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             imem_ready;
  logic             dmem_ready;
  logic             md_done;
  logic             cu_imem_req;
  logic             cu_dmem_req;
  logic             cu_dmem_we;
  logic             cu_irwrite;
  logic             cu_pcwrite;
  logic             cu_rdwrite;
  logic             cu_md_start;
  logic [2:0]       cu_immtype;
  logic [1:0]       cu_rdtype;
  logic             cu_md_sel;
  logic [2:0]       cu_state;
  logic [1:0]       cu_trap;
  logic [CNT_W-1:0] cu_instret;

  modport master (
    output instr, imem_ready, dmem_ready, md_done,
    input  cu_imem_req, cu_dmem_req, cu_dmem_we, cu_irwrite, cu_pcwrite,
           cu_rdwrite, cu_md_start, cu_immtype, cu_rdtype, cu_md_sel,
           cu_state, cu_trap, cu_instret
  );

  modport slave (
    input  instr, imem_ready, dmem_ready, md_done,
    output cu_imem_req, cu_dmem_req, cu_dmem_we, cu_irwrite, cu_pcwrite,
           cu_rdwrite, cu_md_start, cu_immtype, cu_rdtype, cu_md_sel,
           cu_state, cu_trap, cu_instret
  );
endinterface

// File: rtl/ctrl_fsm_rv32.sv
// Multi-cycle RV32I(M) control unit: fetch/decode/execute/memory/writeback sequencing
// with memory-timeout and illegal-instruction traps and a retired-instruction counter.
module ctrl_fsm_rv32 #(
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 32,
  parameter int MEM_TO   = 15
) (
  input logic            clk,
  input logic            rst,
  ctrl_fsm_rv32_if.slave bus
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_MULDIV = 3'd5, S_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_MD
  } cls_t;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                         IMM_U = 3'b011, IMM_J = 3'b100;
  localparam logic [1:0] RD_ALU = 2'b00, RD_MEM = 2'b01, RD_PC4 = 2'b10, RD_IMM = 2'b11;
  localparam logic [1:0] TRAP_NONE = 2'b00, TRAP_ILL = 2'b01, TRAP_BUS = 2'b10;

  // The wait counter holds 0..MEM_TO-1; the MEM_TO-th idle cycle is the fault point.
  localparam int WAIT_W = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

  state_t           r_state;
  cls_t             r_cls;
  logic [31:0]      r_ir;
  logic [WAIT_W-1:0] r_wait;
  logic             r_imem_req, r_dmem_req, r_dmem_we;
  logic             r_irwrite, r_pcwrite, r_rdwrite, r_md_start;
  logic [2:0]       r_immtype;
  logic [1:0]       r_rdtype;
  logic             r_md_sel;
  logic [1:0]       r_trap;
  logic [CNT_W-1:0] r_instret;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_illegal;
  logic [2:0] w_immtype;
  logic [1:0] w_rdtype;
  logic       w_md_sel;
  cls_t       w_cls;

  assign w_op = r_ir[6:0];
  assign w_f3 = r_ir[14:12];
  assign w_f7 = r_ir[31:25];

  always_comb begin
    w_illegal = 1'b0;
    w_immtype = IMM_I;
    w_rdtype  = RD_ALU;
    w_md_sel  = 1'b0;
    w_cls     = CLS_ALU;
    case (w_op)
      7'h33: if (w_f7 == 7'h01) begin
        w_cls     = CLS_MD;
        w_rdtype  = RD_IMM;
        w_md_sel  = 1'b1;
        w_illegal = (ENABLE_M == 0);
      end
      7'h13: w_cls = CLS_ALU;
      7'h03: begin
        w_cls     = CLS_LOAD;
        w_rdtype  = RD_MEM;
        w_illegal = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      7'h23: begin
        w_cls     = CLS_STORE;
        w_immtype = IMM_S;
        w_illegal = (w_f3 > 3'd2);
      end
      7'h63: begin
        w_cls     = CLS_BRANCH;
        w_immtype = IMM_B;
        w_illegal = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      7'h6F: begin
        w_cls     = CLS_JUMP;
        w_immtype = IMM_J;
        w_rdtype  = RD_PC4;
      end
      7'h67: begin
        w_cls    = CLS_JUMP;
        w_rdtype = RD_PC4;
      end
      7'h37: begin
        w_immtype = IMM_U;
        w_rdtype  = RD_IMM;
      end
      7'h17: w_immtype = IMM_U;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FETCH && r_imem_req && bus.imem_ready) r_ir <= bus.instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_cls      <= CLS_ALU;
      r_wait     <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_irwrite  <= 1'b0;
      r_pcwrite  <= 1'b0;
      r_rdwrite  <= 1'b0;
      r_md_start <= 1'b0;
      r_immtype  <= IMM_I;
      r_rdtype   <= RD_ALU;
      r_md_sel   <= 1'b0;
      r_trap     <= TRAP_NONE;
      r_instret  <= '0;
    end else begin
      r_irwrite  <= 1'b0;
      r_pcwrite  <= 1'b0;
      r_rdwrite  <= 1'b0;
      r_md_start <= 1'b0;
      r_wait     <= '0;
      if (r_pcwrite) r_instret <= r_instret + CNT_W'(1);
      case (r_state)
        S_FETCH: begin
          // The first cycle after reset only raises the request; ready is honoured once it is up.
          r_imem_req <= 1'b1;
          if (r_imem_req) begin
            if (bus.imem_ready) begin
              r_imem_req <= 1'b0;
              r_irwrite  <= 1'b1;
              r_state    <= S_DECODE;
            end else if (r_wait == WAIT_LAST) begin
              r_imem_req <= 1'b0;
              r_trap     <= TRAP_BUS;
              r_state    <= S_HALT;
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            r_trap  <= TRAP_ILL;
            r_state <= S_HALT;
          end else begin
            r_immtype <= w_immtype;
            r_rdtype  <= w_rdtype;
            r_md_sel  <= w_md_sel;
            r_cls     <= w_cls;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_cls)
            CLS_LOAD, CLS_STORE: begin
              r_dmem_req <= 1'b1;
              r_dmem_we  <= (r_cls == CLS_STORE);
              r_state    <= S_MEM;
            end
            CLS_MD: begin
              r_md_start <= 1'b1;
              r_state    <= S_MULDIV;
            end
            CLS_BRANCH: begin
              r_pcwrite  <= 1'b1;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end
            default: begin
              r_rdwrite <= 1'b1;
              r_pcwrite <= 1'b1;
              r_state   <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          // Ready wins over a timeout landing in the same cycle.
          if (bus.dmem_ready) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pcwrite  <= 1'b1;
            if (r_cls == CLS_STORE) begin
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_rdwrite <= 1'b1;
              r_state   <= S_WB;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_trap     <= TRAP_BUS;
            r_state    <= S_HALT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_MULDIV: begin
          if (bus.md_done) begin
            r_rdwrite <= 1'b1;
            r_pcwrite <= 1'b1;
            r_state   <= S_WB;
          end
        end
        S_WB: begin
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
        end
        default: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.cu_imem_req = r_imem_req;
  assign bus.cu_dmem_req = r_dmem_req;
  assign bus.cu_dmem_we  = r_dmem_we;
  assign bus.cu_irwrite  = r_irwrite;
  assign bus.cu_pcwrite  = r_pcwrite;
  assign bus.cu_rdwrite  = r_rdwrite;
  assign bus.cu_md_start = r_md_start;
  assign bus.cu_immtype  = r_immtype;
  assign bus.cu_rdtype   = r_rdtype;
  assign bus.cu_md_sel   = r_md_sel;
  assign bus.cu_state    = r_state;
  assign bus.cu_trap     = r_trap;
  assign bus.cu_instret  = r_instret;
endmodule

// File: tb/tb_ctrl_fsm_rv32.sv
// Directed bench for ctrl_fsm_rv32: one M-enabled 4-bit-counter unit and one M-disabled unit share stimulus.
module tb_ctrl_fsm_rv32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, md_done;
  int          checks = 0;
  int          errors = 0;
  int          rdw_cnt;
  int          mds_cnt;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_BADL = 32'h00003003;

  ctrl_fsm_rv32_if #(.CNT_W(4))  ifa ();
  ctrl_fsm_rv32_if #(.CNT_W(32)) ifb ();

  assign ifa.instr      = instr;
  assign ifa.imem_ready = imem_ready;
  assign ifa.dmem_ready = dmem_ready;
  assign ifa.md_done    = md_done;
  assign ifb.instr      = instr;
  assign ifb.imem_ready = imem_ready;
  assign ifb.dmem_ready = dmem_ready;
  assign ifb.md_done    = md_done;

  ctrl_fsm_rv32 #(.ENABLE_M(1), .CNT_W(4), .MEM_TO(15)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  ctrl_fsm_rv32 #(.ENABLE_M(0), .CNT_W(32), .MEM_TO(15)) u_dut_nom (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    instr      = w;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0; md_done = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_state",    32'(ifa.cu_state), 0);
    chk("rst_imem_req", 32'(ifa.cu_imem_req), 0);
    chk("rst_instret",  32'(ifa.cu_instret), 0);
    chk("rst_trap",     32'(ifa.cu_trap), 0);
    chk("rst_rdtype",   32'(ifa.cu_rdtype), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_imem_req", 32'(ifa.cu_imem_req), 1);
    chk("post_rst_state",    32'(ifa.cu_state), 0);

    // ADDI: 0,1,2,4,0
    rdw_cnt = 0;
    fetch(I_ADDI);
    chk("addi_decode", 32'(ifa.cu_state), 1);
    chk("addi_irwrite", 32'(ifa.cu_irwrite), 1);
    rdw_cnt += int'(ifa.cu_rdwrite);
    tick();
    chk("addi_exec", 32'(ifa.cu_state), 2);
    chk("addi_immtype", 32'(ifa.cu_immtype), 0);
    chk("addi_rdtype", 32'(ifa.cu_rdtype), 0);
    rdw_cnt += int'(ifa.cu_rdwrite);
    tick();
    chk("addi_wb", 32'(ifa.cu_state), 4);
    chk("addi_wb_pcwrite", 32'(ifa.cu_pcwrite), 1);
    rdw_cnt += int'(ifa.cu_rdwrite);
    tick();
    chk("addi_fetch", 32'(ifa.cu_state), 0);
    chk("addi_instret", 32'(ifa.cu_instret), 1);
    rdw_cnt += int'(ifa.cu_rdwrite);
    tick();
    rdw_cnt += int'(ifa.cu_rdwrite);
    chk("addi_rdwrite_cnt", 32'(rdw_cnt), 1);

    // LW: MEM held 4 cycles, ready on the 4th
    fetch(I_LW);
    tick();
    chk("lw_rdtype", 32'(ifa.cu_rdtype), 1);
    tick();
    chk("lw_mem1", 32'(ifa.cu_state), 3);
    chk("lw_dmem_req", 32'(ifa.cu_dmem_req), 1);
    chk("lw_dmem_we", 32'(ifa.cu_dmem_we), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_mem_hold", 32'(ifa.cu_state), 3);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("lw_wb", 32'(ifa.cu_state), 4);
    chk("lw_wb_rdwrite", 32'(ifa.cu_rdwrite), 1);
    chk("lw_wb_dmem_req", 32'(ifa.cu_dmem_req), 0);
    tick();
    chk("lw_instret", 32'(ifa.cu_instret), 2);

    // MUL: muldiv path on u_dut, illegal on u_dut_nom
    fetch(I_MUL);
    chk("mul_decode", 32'(ifa.cu_state), 1);
    tick();
    chk("mul_exec", 32'(ifa.cu_state), 2);
    chk("mul_nom_halt", 32'(ifb.cu_state), 6);
    chk("mul_nom_trap", 32'(ifb.cu_trap), 1);
    mds_cnt = 0;
    tick();
    chk("mul_muldiv", 32'(ifa.cu_state), 5);
    chk("mul_md_sel", 32'(ifa.cu_md_sel), 1);
    chk("mul_rdtype", 32'(ifa.cu_rdtype), 3);
    mds_cnt += int'(ifa.cu_md_start);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mul_wait", 32'(ifa.cu_state), 5);
      mds_cnt += int'(ifa.cu_md_start);
    end
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("mul_wb", 32'(ifa.cu_state), 4);
    chk("mul_wb_md_sel", 32'(ifa.cu_md_sel), 1);
    chk("mul_wb_rdwrite", 32'(ifa.cu_rdwrite), 1);
    chk("mul_md_start_cnt", 32'(mds_cnt), 1);
    chk("mul_nom_imem_req", 32'(ifb.cu_imem_req), 0);
    chk("mul_nom_pcwrite", 32'(ifb.cu_pcwrite), 0);
    tick();
    chk("mul_instret", 32'(ifa.cu_instret), 3);

    // BEQ: EXEC straight to FETCH with pcwrite
    fetch(I_BEQ);
    tick();
    chk("beq_immtype", 32'(ifa.cu_immtype), 2);
    tick();
    chk("beq_fetch", 32'(ifa.cu_state), 0);
    chk("beq_pcwrite", 32'(ifa.cu_pcwrite), 1);
    chk("beq_imem_req", 32'(ifa.cu_imem_req), 1);
    tick();
    chk("beq_instret", 32'(ifa.cu_instret), 4);
    chk("beq_pcwrite_off", 32'(ifa.cu_pcwrite), 0);

    // SW: ready on the 15th MEM cycle counts as success; md_done ignored in MEM
    fetch(I_SW);
    tick();
    chk("sw_immtype", 32'(ifa.cu_immtype), 1);
    tick();
    chk("sw_mem1", 32'(ifa.cu_state), 3);
    chk("sw_dmem_we", 32'(ifa.cu_dmem_we), 1);
    md_done = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sw_mem15", 32'(ifa.cu_state), 3);
    md_done = 1'b0;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("sw_edge_fetch", 32'(ifa.cu_state), 0);
    chk("sw_edge_pcwrite", 32'(ifa.cu_pcwrite), 1);
    chk("sw_edge_trap", 32'(ifa.cu_trap), 0);
    tick();
    chk("sw_instret", 32'(ifa.cu_instret), 5);

    // SW with no ready: bus fault after 15 wait cycles
    fetch(I_SW);
    tick(); tick();
    chk("swto_mem1", 32'(ifa.cu_state), 3);
    for (int i = 0; i < 14; i++) tick();
    chk("swto_mem15", 32'(ifa.cu_state), 3);
    tick();
    chk("swto_halt", 32'(ifa.cu_state), 6);
    chk("swto_trap", 32'(ifa.cu_trap), 2);
    chk("swto_dmem_req", 32'(ifa.cu_dmem_req), 0);
    imem_ready = 1'b1; md_done = 1'b1; dmem_ready = 1'b1;
    tick(); tick();
    chk("halt_absorb", 32'(ifa.cu_state), 6);
    chk("halt_imem_req", 32'(ifa.cu_imem_req), 0);
    chk("halt_irwrite", 32'(ifa.cu_irwrite), 0);
    chk("halt_pcwrite", 32'(ifa.cu_pcwrite), 0);
    imem_ready = 1'b0; md_done = 1'b0; dmem_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("halt_rst_state", 32'(ifa.cu_state), 0);
    chk("halt_rst_trap", 32'(ifa.cu_trap), 0);
    chk("halt_rst_instret", 32'(ifa.cu_instret), 0);
    rst = 1'b0;
    tick();
    chk("halt_rst_imem_req", 32'(ifa.cu_imem_req), 1);

    // Reset while in MEM
    fetch(I_NOP);
    tick(); tick(); tick();
    chk("nop_instret", 32'(ifa.cu_instret), 1);
    fetch(I_LW);
    tick(); tick(); tick();
    chk("rstmem_in_mem", 32'(ifa.cu_state), 3);
    rst = 1'b1;
    tick();
    chk("rstmem_state", 32'(ifa.cu_state), 0);
    chk("rstmem_dmem_req", 32'(ifa.cu_dmem_req), 0);
    chk("rstmem_instret", 32'(ifa.cu_instret), 0);
    rst = 1'b0;
    tick();

    // 17 NOPs: the 4-bit counter wraps to 1
    for (int n = 0; n < 17; n++) begin
      fetch(I_NOP);
      tick(); tick(); tick();
    end
    chk("wrap_instret4", 32'(ifa.cu_instret), 1);
    chk("wrap_instret32", ifb.cu_instret, 17);

    // Undefined load funct3 is illegal
    fetch(I_BADL);
    tick();
    chk("badload_halt", 32'(ifa.cu_state), 6);
    chk("badload_trap", 32'(ifa.cu_trap), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
